// File: rtl/adc_rx_pkg.sv
// Shared constants and FSM encoding for the ADC receive deserializer.
package adc_rx_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned N_CH       = 8;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StShift = 2'd2
  } rx_state_e;

endpackage

// File: rtl/adc_rx_deser_if.sv
// Tagged-word stream from the deserializer FIFO head toward the packetizer.
interface adc_rx_deser_if #(
  parameter int unsigned DataW = adc_rx_pkg::DATA_W,
  parameter int unsigned ChW   = adc_rx_pkg::CH_W
);

  logic [DataW-1:0] dout_data;
  logic [ChW-1:0]   dout_ch;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout_data,
    output dout_ch,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout_data,
    input  dout_ch,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/adc_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; Depth must be a power of 2 (>= 2).
module adc_rx_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  // A pop frees a slot in the same cycle, so push-while-full is accepted then.
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & full_o & ~do_pop;

  // Head is forced to zero when empty so outputs read 0 after reset.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

  // Pointer update.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset because the head is gated by empty.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/adc_rx_deser.sv
// Samples the serial ADC pin on fdata_G falling edges, frames words on READ_G
// rising edges, tags them with a channel index and queues them for the host.
module adc_rx_deser
  import adc_rx_pkg::*;
#(
  parameter int unsigned DataW     = DATA_W,
  parameter int unsigned NCh       = N_CH,
  parameter int unsigned ChW       = CH_W,
  parameter int unsigned FifoDepth = FIFO_DEPTH
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic           en,
  input  logic           fdata_g,
  input  logic           read_g,
  input  logic           ch_sync,
  input  logic           sdata_in,
  adc_rx_deser_if.master dout,
  output logic           overflow,
  output logic           frame_err,
  input  logic           clr_flags
);

  localparam int unsigned CntW = $clog2(DataW + 1);

  logic sdata_s1_q, sdata_s2_q;
  logic fdata_d1_q, fdata_d2_q, fdata_d3_q;
  logic read_d1_q, read_d2_q, read_d3_q;
  logic fall_evt, rise_rd;

  rx_state_e        state_q, state_d;
  logic [DataW-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [DataW-1:0] push_word;
  logic             push, ferr_set;

  logic             fifo_ovf;
  logic             fifo_full, fifo_empty;
  logic [ChW+DataW-1:0] fifo_head;

  // Pad synchronizer plus matching 2-cycle delay and edge registers for the clocks.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sdata_s1_q <= 1'b0;
      sdata_s2_q <= 1'b0;
      fdata_d1_q <= 1'b0;
      fdata_d2_q <= 1'b0;
      fdata_d3_q <= 1'b0;
      read_d1_q  <= 1'b0;
      read_d2_q  <= 1'b0;
      read_d3_q  <= 1'b0;
    end else begin
      sdata_s1_q <= sdata_in;
      sdata_s2_q <= sdata_s1_q;
      fdata_d1_q <= fdata_g;
      fdata_d2_q <= fdata_d1_q;
      fdata_d3_q <= fdata_d2_q;
      read_d1_q  <= read_g;
      read_d2_q  <= read_d1_q;
      read_d3_q  <= read_d2_q;
    end
  end

  assign fall_evt  = fdata_d3_q & ~fdata_d2_q;
  assign rise_rd   = read_d2_q & ~read_d3_q;
  assign push_word = {shift_q[DataW-2:0], sdata_s2_q};

  // Framing FSM next-state: a coincident fall_evt is applied before rise_rd.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StArm;
      end
      StArm: begin
        if (!en) begin
          state_d = StIdle;
        end else if (rise_rd) begin
          state_d = StShift;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (!en) begin
          state_d  = StIdle;
          ferr_set = (cnt_q != '0);
        end else begin
          if (fall_evt) begin
            shift_d = push_word;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntW'(DataW - 1)) begin
              push    = 1'b1;
              state_d = StArm;
              ch_d    = (ch_q == ChW'(NCh - 1)) ? '0 : ch_q + ChW'(1);
            end
          end
          if (rise_rd) begin
            // Still mid-word after the bit above: the partial word is abandoned.
            if (state_d == StShift) ferr_set = 1'b1;
            state_d = StShift;
            shift_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // The pushed word already took ch_q; only the following push sees channel 0.
    if (ch_sync) ch_d = '0;
  end

  // Framing FSM state and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  // Sticky flags; a set event beats a simultaneous clear.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_flags) | fifo_ovf;
      frame_err <= (frame_err & ~clr_flags) | ferr_set;
    end
  end

  adc_rx_fifo #(
    .Width (ChW + DataW),
    .Depth (FifoDepth)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .push_i     (push),
    .data_i     ({ch_q, push_word}),
    .pop_i      (dout.dout_ready),
    .data_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_ovf)
  );

  assign dout.dout_valid = ~fifo_empty;
  assign dout.dout_data  = fifo_head[DataW-1:0];
  assign dout.dout_ch    = fifo_head[ChW+DataW-1:DataW];

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_adc_rx_deser.sv
// Scoreboard bench for adc_rx_deser: frames are serialized from directed
// words, expected {ch, word} entries are queued, a monitor pops and compares.
module tb_adc_rx_deser;
  import adc_rx_pkg::*;

  localparam int Half = 4;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic fdata_g = 1'b0;
  logic read_g = 1'b0;
  logic ch_sync = 1'b0;
  logic sdata_in = 1'b0;
  logic clr_flags = 1'b0;
  logic overflow, frame_err;

  int checks = 0;
  int failures = 0;

  logic [CH_W+DATA_W-1:0] exp_q[$];
  logic [CH_W-1:0]        tb_ch = '0;

  adc_rx_deser_if dout_if ();

  adc_rx_deser dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .en        (en),
    .fdata_g   (fdata_g),
    .read_g    (read_g),
    .ch_sync   (ch_sync),
    .sdata_in  (sdata_in),
    .dout      (dout_if.master),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_flags (clr_flags)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: compares each accepted head entry against the scoreboard.
  always @(negedge sys_clk) begin
    if (!rst && dout_if.dout_valid && dout_if.dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word actual data=%h ch=%0d required none",
                 dout_if.dout_data, dout_if.dout_ch);
      end else begin
        logic [CH_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({dout_if.dout_ch, dout_if.dout_data} !== e) begin
          failures++;
          $display("FAIL word_mismatch actual data=%h ch=%0d required data=%h ch=%0d",
                   dout_if.dout_data, dout_if.dout_ch, e[DATA_W-1:0], e[CH_W+DATA_W-1:DATA_W]);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic frame_start();
    read_g = 1'b1;
    tick(2);
    read_g = 1'b0;
    tick(1);
  endtask

  task automatic send_bit(input logic b);
    sdata_in = b;
    fdata_g  = 1'b1;
    tick(Half);
    fdata_g  = 1'b0;
    tick(Half);
  endtask

  // Frame start plus the first n bits of w, MSB first.
  task automatic send_partial(input logic [DATA_W-1:0] w, input int n);
    frame_start();
    for (int i = 0; i < n; i++) send_bit(w[DATA_W-1-i]);
  endtask

  // Complete frame; expected entry queued only if the FIFO should accept it.
  task automatic send_frame(input logic [DATA_W-1:0] w, input bit deliver);
    if (deliver) exp_q.push_back({tb_ch, w});
    tb_ch = (tb_ch == CH_W'(N_CH - 1)) ? '0 : tb_ch + 1'b1;
    send_partial(w, DATA_W);
  endtask

  task automatic pulse_ch_sync();
    ch_sync = 1'b1;
    tick(1);
    ch_sync = 1'b0;
    tb_ch   = '0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    dout_if.dout_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(dout_if.dout_valid), 32'd0);
    check("rst_data", 32'(dout_if.dout_data), 32'd0);
    check("rst_ch", 32'(dout_if.dout_ch), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // First word 0xA5C3 on channel 0, with the push latency checked.
    en = 1'b1;
    tick(1);
    pulse_ch_sync();
    exp_q.push_back({tb_ch, 16'hA5C3});
    tb_ch = tb_ch + 1'b1;
    send_partial(16'hA5C3, DATA_W - 1);
    sdata_in = 1'b1;
    fdata_g  = 1'b1;
    tick(Half);
    fdata_g  = 1'b0;
    tick(2);
    check("lat_valid_early", 32'(dout_if.dout_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(dout_if.dout_valid), 32'd1);
    check("first_data", 32'(dout_if.dout_data), 32'hA5C3);
    check("first_ch", 32'(dout_if.dout_ch), 32'd0);
    check("first_frame_err", 32'(frame_err), 32'd0);
    tick(2);
    dout_if.dout_ready = 1'b1;
    wait_drain("drain_first");

    // Nine back-to-back frames: channels 0..7 then 0.
    pulse_ch_sync();
    for (int i = 0; i < 9; i++) send_frame(16'h1000 + 16'(i * 16'h0111), 1'b1);
    wait_drain("drain_nine");
    check("nine_overflow", 32'(overflow), 32'd0);
    check("nine_frame_err", 32'(frame_err), 32'd0);

    // Five frames into a depth-4 FIFO with no consumer.
    dout_if.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(16'hC000 + 16'(i), i < 4);
    tick(2);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_valid", 32'(dout_if.dout_valid), 32'd1);
    dout_if.dout_ready = 1'b1;
    wait_drain("drain_ovf");
    tick(3);
    check("ovf_fifth_absent", 32'(dout_if.dout_valid), 32'd0);
    pulse_clr();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Frame restarted after 7 bits, then a full 0x1234.
    send_partial(16'hFFFF, 7);
    send_frame(16'h1234, 1'b1);
    wait_drain("drain_restart");
    check("restart_frame_err", 32'(frame_err), 32'd1);
    pulse_clr();
    check("restart_cleared", 32'(frame_err), 32'd0);

    // en drops after 10 bits.
    send_partial(16'h0F0F, 10);
    en = 1'b0;
    tick(3);
    check("endrop_frame_err", 32'(frame_err), 32'd1);
    check("endrop_no_push", 32'(dout_if.dout_valid), 32'd0);
    pulse_clr();
    check("endrop_cleared", 32'(frame_err), 32'd0);
    en = 1'b1;
    tick(2);
    send_frame(16'hBEEF, 1'b1);
    wait_drain("drain_reenable");
    check("reenable_frame_err", 32'(frame_err), 32'd0);

    // Reset mid-SHIFT with two words held and frame_err set.
    dout_if.dout_ready = 1'b0;
    send_partial(16'h0000, 3);
    send_frame(16'h1111, 1'b1);
    send_frame(16'h2222, 1'b1);
    check("pre_rst_frame_err", 32'(frame_err), 32'd1);
    check("pre_rst_valid", 32'(dout_if.dout_valid), 32'd1);
    send_partial(16'hFFFF, 5);
    rst = 1'b1;
    tick(1);
    check("midrst_valid", 32'(dout_if.dout_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_data", 32'(dout_if.dout_data), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tb_ch = '0;
    dout_if.dout_ready = 1'b1;
    tick(2);
    send_frame(16'h5A5A, 1'b1);
    wait_drain("drain_post_rst");
    tick(3);
    check("final_valid", 32'(dout_if.dout_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
